// File: rtl/seg_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter feeding the
// 6-digit scanning display driver.
package seg_pkg;

    localparam int unsigned WIDTH_DEF  = 24;
    localparam int unsigned DIGITS_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] max_bcd_val(input int unsigned digits);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL_DEF = max_bcd_val(DIGITS_DEF);

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-nibble double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/seg_bcd_seq.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with start/busy/done
// handshake; the result register holds the last conversion for display.
module seg_bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iStart,
    input  logic [WIDTH-1:0]      iBin,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic                  oOvf,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam logic [63:0] MAX_VAL = max_bcd_val(DIGITS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    bin_d      = iBin;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (64'(iBin) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Scratch MSB falls off the top, leaving the value mod 10^DIGITS.
                {scr_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oBCD  = bcd_q;
    assign oOvf  = ovf_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_seg_bcd_seq.sv
// Directed bench for seg_bcd_seq: latency, busy width, overflow, ignored
// starts, back-to-back conversions and asynchronous abort.
module tb_seg_bcd_seq;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [23:0] iBin;
    logic [23:0] oBCD;
    logic        oOvf;
    logic        oBusy;
    logic        oDone;

    int vectors;
    int miscompares;

    seg_bcd_seq #(.WIDTH(24), .DIGITS(6)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iStart (iStart),
        .iBin   (iBin),
        .oBCD   (oBCD),
        .oOvf   (oOvf),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion: start at a negedge, then count negedges until oDone.
    // n = 0 is the negedge right after the accepting edge. A stray start
    // pulse and iBin changes are injected from n = glitch_n onwards.
    task automatic conv(input string tag, input logic [23:0] val,
                        input logic [23:0] exp_bcd, input logic exp_ovf,
                        input int glitch_n);
        int n;
        int busy_cnt;
        bit seen;
        @(negedge iCLK);
        iBin   = val;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart   = 1'b0;
        n        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            if (oBusy) busy_cnt++;
            if (oDone) begin
                seen = 1'b1;
            end else begin
                if (n == glitch_n) begin
                    iStart = 1'b1;
                    iBin   = 24'd77;
                end else if (n == glitch_n + 1) begin
                    iStart = 1'b0;
                    iBin   = 24'hABCDE;
                end else if (n == glitch_n + 2) begin
                    iBin   = 24'd3;
                end
                @(negedge iCLK);
                n++;
            end
        end
        chk({tag, "_latency"}, 64'(n), 64'd25);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd25);
        chk({tag, "_bcd"}, 64'(oBCD), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(oOvf), 64'(exp_ovf));
        @(negedge iCLK);
        chk({tag, "_done_width"}, 64'(oDone), 64'd0);
    endtask

    int extra_done;
    int n1;
    int n2;
    bit seen1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        iRST   = 1'b1;
        iStart = 1'b0;
        iBin   = '0;
        #12;
        chk("reset_bcd",  64'(oBCD),  64'd0);
        chk("reset_ovf",  64'(oOvf),  64'd0);
        chk("reset_busy", 64'(oBusy), 64'd0);
        chk("reset_done", 64'(oDone), 64'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        conv("zero",      24'd0,        24'h000000, 1'b0, 1000);
        conv("max_ok",    24'd999999,   24'h999999, 1'b0, 1000);
        conv("mid",       24'd123456,   24'h123456, 1'b0, 1000);
        conv("ovf_1e6",   24'd1000000,  24'h000000, 1'b1, 1000);
        conv("ovf_full",  24'd16777215, 24'h777215, 1'b1, 1000);

        // Start while busy is ignored, iBin changes mid-flight have no effect.
        conv("ignored",   24'd42,       24'h000042, 1'b0, 5);
        extra_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iCLK);
            if (oDone) extra_done++;
        end
        chk("ignored_single_done", 64'(extra_done), 64'd0);
        chk("ignored_hold_bcd", 64'(oBCD), 64'h000042);

        // Back-to-back with iStart held high.
        @(negedge iCLK);
        iBin   = 24'd5;
        iStart = 1'b1;
        @(negedge iCLK);
        iBin  = 24'd9;
        n1    = -1;
        n2    = -1;
        seen1 = 1'b0;
        for (int n = 0; n < 60 && n2 < 0; n++) begin
            if (n == 26) iStart = 1'b0;
            if (oDone) begin
                if (!seen1) begin
                    n1    = n;
                    seen1 = 1'b1;
                    chk("b2b_first_bcd", 64'(oBCD), 64'h000005);
                end else begin
                    n2 = n;
                    chk("b2b_second_bcd", 64'(oBCD), 64'h000009);
                end
            end
            @(negedge iCLK);
        end
        chk("b2b_first_latency", 64'(n1), 64'd25);
        chk("b2b_gap", 64'(n2 - n1), 64'd26);

        // Asynchronous abort mid-conversion.
        @(negedge iCLK);
        iBin   = 24'd654321;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        chk("abort_busy_before", 64'(oBusy), 64'd1);
        #1;
        iRST = 1'b1;
        #1;
        chk("abort_bcd",  64'(oBCD),  64'd0);
        chk("abort_ovf",  64'(oOvf),  64'd0);
        chk("abort_busy", 64'(oBusy), 64'd0);
        chk("abort_done", 64'(oDone), 64'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iCLK);
            if (oDone || oBusy) extra_done++;
        end
        chk("abort_no_done", 64'(extra_done), 64'd0);
        conv("after_abort", 24'd31, 24'h000031, 1'b0, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
